// File: rtl/lab4_mcore_refill_arbiter_pkg.sv
// Shared message types and port constants for the icache/dcache refill arbiter.
package lab4_mcore_refill_arbiter_pkg;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  localparam int REQ_ID_W = 1;
  localparam logic [REQ_ID_W-1:0] ICACHE_PORT = 1'b0;
  localparam logic [REQ_ID_W-1:0] DCACHE_PORT = 1'b1;

endpackage

// File: rtl/lab4_mcore_refill_arb_idq.sv
// In-order queue of requester IDs for requests in flight to memory.
module lab4_mcore_refill_arb_idq
  import lab4_mcore_refill_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [REQ_ID_W-1:0] push_id,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [REQ_ID_W-1:0] head_id,
  output logic [CW-1:0]       count
);

  logic [DEPTH-1:0][REQ_ID_W-1:0] ids;
  logic [PW-1:0] head, tail;
  logic do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle never frees room for a push into a full queue.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = ids[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        ids[tail] <= push_id;
        tail      <= tail + PW'(1);
      end
      if (do_pop) head <= head + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/lab4_mcore_refill_arbiter.sv
// Round-robin merge of icache/dcache refill traffic onto one memory port.
// Define LAB4_MCORE_REFILL_ARBITER_PIPE_EN to register the outgoing request.
module lab4_mcore_refill_arbiter
  import lab4_mcore_refill_arbiter_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  mem_req_16B_t  imemreq_msg,
  input  logic          imemreq_val,
  output logic          imemreq_rdy,
  input  mem_req_16B_t  dmemreq_msg,
  input  logic          dmemreq_val,
  output logic          dmemreq_rdy,
  output mem_resp_16B_t imemresp_msg,
  output logic          imemresp_val,
  input  logic          imemresp_rdy,
  output mem_resp_16B_t dmemresp_msg,
  output logic          dmemresp_val,
  input  logic          dmemresp_rdy,
  output mem_req_16B_t  memreq_msg,
  output logic          memreq_val,
  input  logic          memreq_rdy,
  input  mem_resp_16B_t memresp_msg,
  input  logic          memresp_val,
  output logic          memresp_rdy
);

  localparam int CW = $clog2(p_max_outstanding + 1);

  logic                prio;
  logic                grant0, grant1, space, accept_ok, fire;
  logic                idq_full, idq_empty, idq_pop;
  logic [REQ_ID_W-1:0] head_id, req_id;
  logic [CW-1:0]       idq_count;
  mem_req_16B_t        req_mux;

  assign grant0    = imemreq_val & (~prio | ~dmemreq_val);
  assign grant1    = dmemreq_val & ( prio | ~imemreq_val);
  assign req_id    = grant1 ? DCACHE_PORT : ICACHE_PORT;
  assign req_mux   = grant1 ? dmemreq_msg : imemreq_msg;
  assign accept_ok = space & ~idq_full & ~reset;
  assign imemreq_rdy = (~prio | ~dmemreq_val) & accept_ok;
  assign dmemreq_rdy = ( prio | ~imemreq_val) & accept_ok;
  assign fire      = (grant0 | grant1) & accept_ok;

`ifdef LAB4_MCORE_REFILL_ARBITER_PIPE_EN
  logic         buf_valid;
  mem_req_16B_t buf_msg;

  // Buffer may refill in the same cycle it drains.
  assign space      = ~buf_valid | memreq_rdy;
  assign memreq_val = buf_valid & ~reset;
  assign memreq_msg = buf_msg;

  always_ff @(posedge clk) begin
    if (reset) buf_valid <= 1'b0;
    else if (fire) begin
      buf_valid <= 1'b1;
      buf_msg   <= req_mux;
    end else if (memreq_rdy) buf_valid <= 1'b0;
  end
`else
  assign space      = memreq_rdy;
  assign memreq_val = (grant0 | grant1) & ~idq_full & ~reset;
  assign memreq_msg = req_mux;
`endif

  always_ff @(posedge clk) begin
    if (reset)     prio <= 1'b0;
    else if (fire) prio <= (req_id == ICACHE_PORT);
  end

  // Responses return in order; the queue head names their owner.
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign imemresp_val = memresp_val & ~idq_empty & ~reset & (head_id == ICACHE_PORT);
  assign dmemresp_val = memresp_val & ~idq_empty & ~reset & (head_id == DCACHE_PORT);
  assign memresp_rdy  = ~idq_empty & ~reset &
                        ((head_id == DCACHE_PORT) ? dmemresp_rdy : imemresp_rdy);
  assign idq_pop      = memresp_val & memresp_rdy;

  lab4_mcore_refill_arb_idq #(.DEPTH(p_max_outstanding)) u_idq (
    .clk     (clk),
    .reset   (reset),
    .push    (fire),
    .push_id (req_id),
    .pop     (idq_pop),
    .full    (idq_full),
    .empty   (idq_empty),
    .head_id (head_id),
    .count   (idq_count)
  );

`ifndef SYNTHESIS
  function automatic string line_trace();
    return $sformatf("g:%s q:%0d r:%s",
                     fire ? (grant1 ? "D" : "I") : ".", idq_count,
                     idq_pop ? ((head_id == DCACHE_PORT) ? "D" : "I") : ".");
  endfunction

  always_ff @(posedge clk)
    if (!reset) assert (!(memresp_val && idq_empty))
      else $error("memory response with no request outstanding");
`endif

endmodule

// File: tb/tb_lab4_mcore_refill_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_lab4_mcore_refill_arbiter;
  import lab4_mcore_refill_arbiter_pkg::*;

`ifdef LAB4_MCORE_REFILL_ARBITER_PIPE_EN
  localparam int REQ_LAT = 1;
`else
  localparam int REQ_LAT = 0;
`endif
  localparam int DEPTH = 4;

  logic clk = 1'b0, reset = 1'b1;
  mem_req_16B_t  imemreq_msg, dmemreq_msg, memreq_msg;
  mem_resp_16B_t imemresp_msg, dmemresp_msg, memresp_msg;
  logic imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
  logic imemresp_val, imemresp_rdy, dmemresp_val, dmemresp_rdy;
  logic memreq_val, memreq_rdy, memresp_val, memresp_rdy;

  always #5 clk = ~clk;

  lab4_mcore_refill_arbiter #(.p_max_outstanding(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy)
  );

  typedef struct { logic port; logic [7:0] opaque; } exp_t;
  typedef struct { mem_resp_16B_t msg; int due; } mem_ent_t;

  mem_req_16B_t iq[$], dq[$], exp_req[$];
  exp_t         exp_resp[$];
  mem_ent_t     mq[$];
  int  cyc = 0, checks = 0, errors = 0, outstanding = 0, lat = 1;
  logic ien = 0, den = 0, hold = 0, mreq_rdy = 1, irr = 1, drr = 1;

  logic o_ival, o_dval, o_ifire, o_dfire, o_irdy, o_drdy, o_mval, o_mfire;
  logic o_mresp_val, o_mresp_rdy, o_mresp_fire, o_irval, o_drval, o_irfire, o_drfire;
  mem_req_16B_t  o_mmsg;
  mem_resp_16B_t o_irmsg, o_drmsg;

  // Memory model: echo opaque/type, derive data from the address.
  function automatic mem_resp_16B_t resp_of(mem_req_16B_t r);
    mem_resp_16B_t s;
    s.type_ = r.type_; s.opaque = r.opaque; s.test = 2'b00; s.len = r.len;
    s.data = (r.type_ == MEM_TYPE_WRITE) ? 128'h0 : {4{r.addr ^ 32'h5a5a_0000}};
    return s;
  endfunction

  function automatic mem_req_16B_t mk_req(logic [2:0] t, logic [31:0] a, logic [7:0] op);
    mem_req_16B_t r;
    r.type_ = t; r.opaque = op; r.addr = a; r.len = 4'd0;
    r.data = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  // Drive one cycle from the model, sample away from the edge, advance the model.
  task automatic tick();
    imemreq_val = ien && (iq.size() > 0);
    imemreq_msg = '0; if (iq.size() > 0) imemreq_msg = iq[0];
    dmemreq_val = den && (dq.size() > 0);
    dmemreq_msg = '0; if (dq.size() > 0) dmemreq_msg = dq[0];
    memresp_val = !hold && (mq.size() > 0) && (mq[0].due <= cyc);
    memresp_msg = '0; if (mq.size() > 0) memresp_msg = mq[0].msg;
    memreq_rdy = mreq_rdy; imemresp_rdy = irr; dmemresp_rdy = drr;
    @(negedge clk);
    o_ival = imemreq_val; o_dval = dmemreq_val;
    o_irdy = imemreq_rdy; o_drdy = dmemreq_rdy;
    o_ifire = imemreq_val & imemreq_rdy; o_dfire = dmemreq_val & dmemreq_rdy;
    o_mval = memreq_val; o_mfire = memreq_val & memreq_rdy; o_mmsg = memreq_msg;
    o_mresp_val = memresp_val; o_mresp_rdy = memresp_rdy; o_mresp_fire = memresp_val & memresp_rdy;
    o_irval = imemresp_val; o_drval = dmemresp_val;
    o_irfire = imemresp_val & imemresp_rdy; o_drfire = dmemresp_val & dmemresp_rdy;
    o_irmsg = imemresp_msg; o_drmsg = dmemresp_msg;
    if (!reset) begin
      if (o_ifire) begin
        exp_req.push_back(iq[0]); exp_resp.push_back('{1'b0, iq[0].opaque});
        void'(iq.pop_front()); outstanding++;
      end
      if (o_dfire) begin
        exp_req.push_back(dq[0]); exp_resp.push_back('{1'b1, dq[0].opaque});
        void'(dq.pop_front()); outstanding++;
      end
      if (o_mfire) begin
        int d = cyc + lat;
        if (mq.size() > 0 && mq[$].due > d) d = mq[$].due;
        mq.push_back('{resp_of(memreq_msg), d});
      end
      if (o_mresp_fire) begin void'(mq.pop_front()); outstanding--; end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic clear_model();
    iq.delete(); dq.delete(); exp_req.delete(); exp_resp.delete(); mq.delete();
    outstanding = 0;
  endtask

  task automatic do_reset();
    reset = 1; ien = 0; den = 0; hold = 0; lat = 1; mreq_rdy = 1; irr = 1; drr = 1;
    clear_model();
    tick(); tick();
    reset = 0;
  endtask

  task automatic drain(output logic ok);
    ien = 0; den = 0; hold = 0; mreq_rdy = 1; irr = 1; drr = 1;
    iq.delete(); dq.delete();
    for (int k = 0; k < 60 && (outstanding > 0 || o_mval); k++) tick();
    ok = (outstanding == 0);
  endtask

  task automatic test_reset();
    reset = 1; ien = 1; den = 1; mreq_rdy = 1;
    iq.push_back(mk_req(MEM_TYPE_READ, 32'h100, 8'h01));
    dq.push_back(mk_req(MEM_TYPE_READ, 32'h200, 8'h02));
    tick();
    checks++; if (o_irdy !== 1'b0) begin errors++; $display("FAIL reset_irdy: got %0b want 0", o_irdy); end
    checks++; if (o_drdy !== 1'b0) begin errors++; $display("FAIL reset_drdy: got %0b want 0", o_drdy); end
    checks++; if (o_mval !== 1'b0) begin errors++; $display("FAIL reset_memreq_val: got %0b want 0", o_mval); end
    checks++; if (o_mresp_rdy !== 1'b0) begin errors++; $display("FAIL reset_memresp_rdy: got %0b want 0", o_mresp_rdy); end
    checks++; if ({o_irval, o_drval} !== 2'b00) begin errors++; $display("FAIL reset_resp_val: got %0b want 00", {o_irval, o_drval}); end
    clear_model(); ien = 0; den = 0; reset = 0;
    tick();
    checks++; if ({o_irdy, o_drdy} !== 2'b11) begin errors++; $display("FAIL idle_rdy: got %0b want 11", {o_irdy, o_drdy}); end
    checks++; if (o_mval !== 1'b0) begin errors++; $display("FAIL idle_memreq_val: got %0b want 0", o_mval); end
  endtask

  task automatic test_single_icache();
    mem_req_16B_t r; mem_resp_16B_t got_msg; mem_req_16B_t mmsg;
    int mf = -1, ff = -1; logic got = 0, dv = 0;
    do_reset();
    r = mk_req(MEM_TYPE_READ, 32'h1000, 8'h05);
    iq.push_back(r); ien = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_ifire && ff < 0) ff = k;
      if (o_mfire && mf < 0) begin mf = k; mmsg = o_mmsg; end
      if (o_drval) dv = 1;
      if (o_irfire) begin got = 1; got_msg = o_irmsg; break; end
    end
    checks++; if (ff != 0) begin errors++; $display("FAIL single_grant_cycle: got %0d want 0", ff); end
    checks++; if (mf != REQ_LAT) begin errors++; $display("FAIL single_memreq_cycle: got %0d want %0d", mf, REQ_LAT); end
    checks++; if (mmsg !== r) begin errors++; $display("FAIL single_memreq_msg: got %0h want %0h", mmsg, r); end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_resp_seen: got %0b want 1", got); end
    checks++; if (got_msg !== resp_of(r)) begin errors++; $display("FAIL single_resp_msg: got %0h want %0h", got_msg, resp_of(r)); end
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL single_dresp_val: got %0b want 0", dv); end
  endtask

  task automatic test_alternate();
    logic ord[$]; int fc[$]; exp_t rs[$];
    logic [7:0] eop[4] = '{8'h10, 8'h20, 8'h11, 8'h21};
    do_reset();
    iq.push_back(mk_req(MEM_TYPE_READ, 32'h2000, 8'h10)); iq.push_back(mk_req(MEM_TYPE_READ, 32'h2010, 8'h11));
    dq.push_back(mk_req(MEM_TYPE_READ, 32'h3000, 8'h20)); dq.push_back(mk_req(MEM_TYPE_WRITE, 32'h3010, 8'h21));
    ien = 1; den = 1;
    for (int k = 0; k < 30 && rs.size() < 4; k++) begin
      tick();
      if (o_ifire) begin ord.push_back(1'b0); fc.push_back(k); end
      if (o_dfire) begin ord.push_back(1'b1); fc.push_back(k); end
      if (o_irfire) rs.push_back('{1'b0, o_irmsg.opaque});
      if (o_drfire) rs.push_back('{1'b1, o_drmsg.opaque});
    end
    checks++; if (ord.size() != 4) begin errors++; $display("FAIL alt_grant_count: got %0d want 4", ord.size()); end
    checks++; if (rs.size() != 4) begin errors++; $display("FAIL alt_resp_count: got %0d want 4", rs.size()); end
    for (int k = 0; k < 4 && k < ord.size(); k++) begin
      checks++; if (ord[k] !== k[0]) begin errors++; $display("FAIL alt_grant_order[%0d]: got %0b want %0b", k, ord[k], k[0]); end
      checks++; if (fc[k] != k) begin errors++; $display("FAIL alt_grant_cycle[%0d]: got %0d want %0d", k, fc[k], k); end
    end
    for (int k = 0; k < 4 && k < rs.size(); k++) begin
      checks++; if (rs[k].port !== k[0] || rs[k].opaque !== eop[k])
        begin errors++; $display("FAIL alt_resp[%0d]: got port %0b op %0h want port %0b op %0h", k, rs[k].port, rs[k].opaque, k[0], eop[k]); end
    end
  endtask

  task automatic test_full();
    int nf = 0; logic ok;
    do_reset();
    hold = 1;
    for (int k = 0; k < 6; k++) begin
      iq.push_back(mk_req(MEM_TYPE_READ, 32'h4000 + k * 16, 8'h60 + 8'(k)));
      dq.push_back(mk_req(MEM_TYPE_READ, 32'h5000 + k * 16, 8'h70 + 8'(k)));
    end
    ien = 1; den = 1;
    for (int k = 0; k < 8; k++) begin tick(); nf += int'(o_ifire) + int'(o_dfire); end
    checks++; if (nf != DEPTH) begin errors++; $display("FAIL full_accepted: got %0d want %0d", nf, DEPTH); end
    checks++; if ({o_irdy, o_drdy} !== 2'b00) begin errors++; $display("FAIL full_rdy: got %0b want 00", {o_irdy, o_drdy}); end
    hold = 0; tick(); hold = 1;
    checks++; if (o_mresp_fire !== 1'b1) begin errors++; $display("FAIL full_pop: got %0b want 1", o_mresp_fire); end
    checks++; if ({o_irdy, o_drdy} !== 2'b00) begin errors++; $display("FAIL full_push_blocked_on_pop: got %0b want 00", {o_irdy, o_drdy}); end
    tick();
    checks++; if ({o_ifire, o_dfire} !== 2'b10) begin errors++; $display("FAIL full_regrant: got %0b want 10", {o_ifire, o_dfire}); end
    drain(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_drain: outstanding %0d want 0", outstanding); end
  endtask

  task automatic test_backpressure();
    mem_resp_16B_t m1; logic seen = 0;
    do_reset();
    drr = 0;
    dq.push_back(mk_req(MEM_TYPE_WRITE, 32'h6000, 8'h33)); den = 1;
    for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = o_mresp_val; end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_resp_seen: got %0b want 1", seen); end
    checks++; if (o_mresp_rdy !== 1'b0) begin errors++; $display("FAIL bp_memresp_rdy: got %0b want 0", o_mresp_rdy); end
    checks++; if ({o_irval, o_drval} !== 2'b01) begin errors++; $display("FAIL bp_route: got %0b want 01", {o_irval, o_drval}); end
    m1 = o_drmsg;
    tick();
    checks++; if (o_drmsg !== m1 || o_mresp_fire !== 1'b0) begin errors++; $display("FAIL bp_hold: got fire %0b msg %0h want fire 0 msg %0h", o_mresp_fire, o_drmsg, m1); end
    drr = 1; tick();
    checks++; if ({o_mresp_fire, o_drfire} !== 2'b11) begin errors++; $display("FAIL bp_release: got %0b want 11", {o_mresp_fire, o_drfire}); end
    checks++; if (o_drmsg.opaque !== 8'h33) begin errors++; $display("FAIL bp_opaque: got %0h want 33", o_drmsg.opaque); end
    tick();
    checks++; if (o_mresp_val !== 1'b0 || outstanding != 0) begin errors++; $display("FAIL bp_popped: got val %0b outst %0d want 0 0", o_mresp_val, outstanding); end
  endtask

  task automatic test_reset_mid();
    int nf = 0; logic ok;
    do_reset();
    hold = 1;
    iq.push_back(mk_req(MEM_TYPE_READ, 32'h7000, 8'h01)); iq.push_back(mk_req(MEM_TYPE_READ, 32'h7010, 8'h02));
    ien = 1;
    for (int k = 0; k < 10 && nf < 2; k++) begin tick(); nf += int'(o_ifire); end
    mreq_rdy = 0; iq.push_back(mk_req(MEM_TYPE_READ, 32'h7020, 8'h03));
    tick();
    reset = 1; clear_model(); ien = 0;
    tick();
    reset = 0; mreq_rdy = 1;
    tick();
    checks++; if ({o_mval, o_irval, o_drval} !== 3'b000) begin errors++; $display("FAIL rst_mid_vals: got %0b want 000", {o_mval, o_irval, o_drval}); end
    checks++; if (o_mresp_rdy !== 1'b0) begin errors++; $display("FAIL rst_mid_queue_empty: memresp_rdy %0b want 0", o_mresp_rdy); end
    for (int k = 0; k < 3; k++) begin
      iq.push_back(mk_req(MEM_TYPE_READ, 32'h8000 + k * 16, 8'h80 + 8'(k)));
      dq.push_back(mk_req(MEM_TYPE_READ, 32'h9000 + k * 16, 8'h90 + 8'(k)));
    end
    ien = 1; den = 1; tick();
    checks++; if ({o_ifire, o_dfire} !== 2'b10) begin errors++; $display("FAIL rst_mid_first_grant: got %0b want 10", {o_ifire, o_dfire}); end
    nf = 1;
    for (int k = 0; k < 8; k++) begin tick(); nf += int'(o_ifire) + int'(o_dfire); end
    checks++; if (nf != DEPTH) begin errors++; $display("FAIL rst_mid_capacity: got %0d want %0d", nf, DEPTH); end
    drain(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_mid_drain: outstanding %0d want 0", outstanding); end
  endtask

  task automatic test_wrap();
    int first = -1, last = -1; exp_t rs[$]; mem_req_16B_t er;
    do_reset();
    lat = 3;
    for (int k = 0; k < 5; k++) begin
      iq.push_back(mk_req(MEM_TYPE_READ, 32'hA000 + k * 16, 8'h40 + 8'(k)));
      dq.push_back(mk_req(MEM_TYPE_READ, 32'hB000 + k * 16, 8'h50 + 8'(k)));
    end
    ien = 1; den = 1;
    for (int k = 0; k < 80 && rs.size() < 10; k++) begin
      tick();
      if (o_ifire || o_dfire) begin if (first < 0) first = k; last = k; end
      if (o_mfire) begin
        er = exp_req.pop_front();
        checks++; if (o_mmsg !== er) begin errors++; $display("FAIL wrap_memreq: got %0h want %0h", o_mmsg, er); end
      end
      if (o_irfire) rs.push_back('{1'b0, o_irmsg.opaque});
      if (o_drfire) rs.push_back('{1'b1, o_drmsg.opaque});
    end
    checks++; if (rs.size() != 10) begin errors++; $display("FAIL wrap_resp_count: got %0d want 10", rs.size()); end
    for (int k = 0; k < rs.size() && k < 10; k++) begin
      logic [7:0] op = (k[0] ? 8'h50 : 8'h40) + 8'(k / 2);
      checks++; if (rs[k].port !== k[0] || rs[k].opaque !== op)
        begin errors++; $display("FAIL wrap_resp[%0d]: got port %0b op %0h want port %0b op %0h", k, rs[k].port, rs[k].opaque, k[0], op); end
    end
`ifndef LAB4_MCORE_REFILL_ARBITER_PIPE_EN
    checks++; if (last - first != 9) begin errors++; $display("FAIL wrap_no_stall: grant span %0d want 9", last - first); end
`endif
  endtask

  task automatic test_random();
    logic pri = 1'b0, win, ok; mem_req_16B_t er; exp_t ee;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      ien = ($urandom_range(0, 3) != 0); den = ($urandom_range(0, 3) != 0);
      if (iq.size() == 0) iq.push_back(mk_req(3'($urandom_range(0, 1)), $urandom, 8'($urandom)));
      if (dq.size() == 0) dq.push_back(mk_req(3'($urandom_range(0, 1)), $urandom, 8'($urandom)));
      mreq_rdy = ($urandom_range(0, 3) != 0); irr = ($urandom_range(0, 3) != 0); drr = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 4) == 0); lat = $urandom_range(1, 4);
      tick();
      if (o_ifire || o_dfire) begin
        win = o_dfire;
        checks++; if (o_ifire && o_dfire) begin errors++; $display("FAIL rnd_double_grant: cycle %0d", cyc); end
        if (o_ival && o_dval) begin
          checks++; if (win !== pri) begin errors++; $display("FAIL rnd_rr_winner: got %0b want %0b", win, pri); end
        end
        pri = ~win;
      end
      if (o_mfire) begin
        checks++;
        if (exp_req.size() == 0) begin errors++; $display("FAIL rnd_memreq_spurious: cycle %0d", cyc); end
        else begin
          er = exp_req.pop_front();
          if (o_mmsg !== er) begin errors++; $display("FAIL rnd_memreq_msg: got %0h want %0h", o_mmsg, er); end
        end
      end
      checks++; if (o_mresp_fire !== (o_irfire | o_drfire) || (o_irval && o_drval))
        begin errors++; $display("FAIL rnd_resp_handshake: memresp %0b iresp %0b dresp %0b", o_mresp_fire, o_irval, o_drval); end
      if (o_irfire || o_drfire) begin
        checks++;
        if (exp_resp.size() == 0) begin errors++; $display("FAIL rnd_resp_spurious: cycle %0d", cyc); end
        else begin
          ee = exp_resp.pop_front();
          if (o_drfire !== ee.port || (o_drfire ? o_drmsg.opaque : o_irmsg.opaque) !== ee.opaque)
            begin errors++; $display("FAIL rnd_resp_route: got port %0b want port %0b op %0h", o_drfire, ee.port, ee.opaque); end
        end
      end
    end
    drain(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd_drain: outstanding %0d want 0", outstanding); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_icache();
    test_alternate();
    test_full();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab4_mcore_refill_arbiter.md
# lab4_mcore_refill_arbiter

Merges the 16B refill/writeback traffic of a core's instruction cache and data cache onto one shared memory port. It sits directly downstream of the single-core processor-cache block and upstream of main memory or the memory-side network. Requests are round-robin arbitrated. The memory returns responses in order, so each response is routed back to its requester using an in-order queue of requester IDs. Opaque fields pass through unmodified.

## Interface
- p_max_outstanding, 4: depth of the requester-ID queue, i.e. the maximum number of requests in flight to memory. Must be a power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imemreq_msg/val/rdy  in/in/out  mem_req_16B_t/1/1  requester port 0 (icache).
- dmemreq_msg/val/rdy  in/in/out  mem_req_16B_t/1/1  requester port 1 (dcache).
- imemresp_msg/val/rdy  out/out/in  mem_resp_16B_t/1/1  response to port 0.
- dmemresp_msg/val/rdy  out/out/in  mem_resp_16B_t/1/1  response to port 1.
- memreq_msg/val/rdy  out/out/in  mem_req_16B_t/1/1  merged request to memory.
- memresp_msg/val/rdy  in/in/out  mem_resp_16B_t/1/1  in-order response from memory.

## Operation
- **Priority register `prio`** (1 bit): reset to 0, so port 0 has priority. After any accepted request from port i, `prio` becomes ~i. `prio` is unchanged in cycles with no grant.
- **Grant**:
  - grant0 = val0 & (prio==0 | ~val1); grant1 = val1 & (prio==1 | ~val0).
  - rdy_i = (prio==i | ~val_other) & space & ~idq_full, where space is "downstream can take a request this cycle".
  - rdy_i never depends on val_i.
- **Request transfer**: a request fires when val_i & rdy_i. The message is forwarded bit-exact, including its opaque field. Port id i is pushed into the ID queue in the same cycle.
- **ID queue**:
  - Circular buffer of p_max_outstanding 1-bit entries, with head pointer, tail pointer and a count of width $clog2(p_max_outstanding+1).
  - Push is blocked when full, even if a pop happens in the same cycle.
  - Pop and push in the same cycle are allowed when not full; count is then unchanged.
  - Pointers wrap modulo p_max_outstanding.
- **Response routing**:
  - h = head ID.
  - resp_val[h] = memresp_val & ~idq_empty; resp_val of the other port is 0.
  - resp_msg of both ports = memresp_msg.
  - memresp_rdy = ~idq_empty & resp_rdy[h].
  - The queue pops when memresp_val & memresp_rdy.
  - A response arriving with the queue empty is never accepted (memresp_rdy=0). Under SYNTHESIS-off this triggers an assertion error.
- **Write requests**: they also produce a response (write ack), so they occupy a queue entry like reads.
- **Reset values**: all val outputs 0, all req rdy 0 during reset, memresp_rdy 0, queue empty, prio 0.
- **Reset mid-operation**: the queue and request buffer are flushed. Memory is reset concurrently, so it has no responses in flight after reset.

## Timing
- Response path is combinational in all configurations: memresp to requester resp, 0-cycle latency.
- Request path latency is 0 cycles without the pipe macro and 1 cycle with it.
- Without the macro:
  - space = memreq_rdy.
  - memreq_val = grant0 | grant1, gated by ~idq_full.
  - memreq_msg is muxed by the grant.
- Back-to-back grants are allowed every cycle. With both ports continuously valid, grants alternate 0,1,0,1.
- Throughput with p_max_outstanding ≥ memory latency + 1 is one request per cycle.

## Configuration
- LAB4_MCORE_REFILL_ARBITER_PIPE_EN defined:
  - The request output is registered in a 1-entry pipe buffer (msg plus valid bit).
  - memreq_val = buffer valid.
  - space = ~buf_valid | memreq_rdy, so the buffer can be refilled in the same cycle it drains.
  - The ID is pushed when the request enters the buffer, not when it leaves.
  - Buffer valid resets to 0.
- Undefined: the request path is purely combinational as described under Timing, with no request register.

## Structure
- Shared package: mem_req_16B_t and mem_resp_16B_t come from the existing memory-message header. Add a constant for requester-ID width (1) and port-index constants ICACHE_PORT=0 and DCACHE_PORT=1.
- Sub-module lab4_mcore_refill_arb_idq: the ID queue, parameterised by depth, with push/pop/full/empty/head ports.
- Grant, priority and optional pipe buffer live in the top module.
- Provide a line_trace showing the grant, queue count and routed port.

## Test plan
- Only icache sends a read to 0x1000 with memory always ready → memreq carries an identical message in cycle 0 (1 with pipe); the response with opaque 0x05 appears only on imemresp and dmemresp_val stays 0.
- Both ports valid for 4 cycles from reset → grant order icache, dcache, icache, dcache; responses return in the same order with matching opaque fields.
- memreq_rdy=1 but memresp withheld, p_max_outstanding=4 → 4 requests are accepted, then both req rdy are 0. One response frees an entry and a grant follows in the next cycle.
- Response arrives with dmemresp_rdy=0 → memresp_rdy=0 and the message is held stable. Raising dmemresp_rdy pops the queue that cycle.
- Reset is asserted with 2 requests outstanding and, in pipe mode, a full buffer → next cycle all val are 0, the queue is empty, and the first new grant goes to icache.
- Queue pointer wrap: 10 alternating requests, each with a 3-cycle memory latency → all 10 responses are routed correctly and no stall occurs beyond the full condition.
